// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 1/2/4-byte data accesses and 4-byte instruction fetches onto a byte-wide RAM.
// Latency: read of L bytes pulses done L+2 cycles after accept; write of L bytes L+1 (+1 per I/O stall cycle).
// Backpressure: one access in flight, requesters hold until their done pulse; rdy_in=0 freezes everything.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global enable (low = pause, mem_wr_out forced 0)
//   *_lsc_*                 load/store controller request/done handshake (priority port)
//   *_if_*                  instruction fetch request/done handshake
//   mem_*                   byte-wide RAM: address/write-data/write-enable out, read byte in (1-cycle latency)
//   io_buffer_full_in       stalls writes to the I/O window (addr[17:16]==2'b11)
//   refresh_rob_cdb_in      misprediction flush: aborts reads, lets writes finish silently
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rdy_data_lsc_in,
    input  logic                  wr_lsc_in,
    input  logic [ADDR_WIDTH-1:0] addr_lsc_in,
    input  logic [2:0]            len_lsc_in,
    input  logic [DATA_WIDTH-1:0] data_s_lsc_in,
    output logic [DATA_WIDTH-1:0] data_l_lsc_out,
    output logic                  rdy_data_lsc_out,
    input  logic                  rdy_if_in,
    input  logic [ADDR_WIDTH-1:0] addr_if_in,
    output logic [DATA_WIDTH-1:0] inst_if_out,
    output logic                  rdy_inst_if_out,
    input  logic [7:0]            mem_din_in,
    output logic [7:0]            mem_dout_out,
    output logic [ADDR_WIDTH-1:0] mem_a_out,
    output logic                  mem_wr_out,
    input  logic                  io_buffer_full_in,
    input  logic                  refresh_rob_cdb_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] FETCH_LEN = 3'd4;

    state_t r_state;
    state_t w_state_nxt;

    // Latched request
    logic                  r_port;      // 1 = fetch port, 0 = data port
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_len;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_cnt;       // bytes whose address has been issued
    logic                  r_squash;    // refresh seen during a write: finish it, no done pulse

    // Byte-index tracking for the read pipeline: r_a_* names the byte whose
    // address is on mem_a_out this cycle, r_din_* the byte now on mem_din_in.
    logic                  r_a_vld;
    logic [1:0]            r_a_idx;
    logic                  r_din_vld;
    logic [1:0]            r_din_idx;
    logic [DATA_WIDTH-1:0] r_rbuf;

    // Registered outputs
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [7:0]            r_mem_dout;
    logic                  r_rdy_data;
    logic                  r_rdy_inst;
    logic [DATA_WIDTH-1:0] r_data_l;
    logic [DATA_WIDTH-1:0] r_inst;

    // Next values
    logic                  w_port_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [2:0]            w_len_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic [2:0]            w_cnt_nxt;
    logic                  w_squash_nxt;
    logic                  w_a_vld_nxt;
    logic [1:0]            w_a_idx_nxt;
    logic                  w_mem_wr_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_a_nxt;
    logic [7:0]            w_mem_dout_nxt;
    logic                  w_rdy_data_nxt;
    logic                  w_rdy_inst_nxt;
    logic [DATA_WIDTH-1:0] w_data_l_nxt;
    logic [DATA_WIDTH-1:0] w_inst_nxt;

    logic [DATA_WIDTH-1:0] w_rbuf_cap;
    logic                  w_rd_last;
    logic                  w_wr_all;
    logic                  w_io_stall_acc;
    logic                  w_io_stall;
    logic                  w_accept;

    assign w_rd_last      = r_din_vld && ({1'b0, r_din_idx} == (r_len - 3'd1));
    assign w_wr_all       = (r_cnt >= r_len);
    assign w_io_stall_acc = (addr_lsc_in[17:16] == 2'b11) && io_buffer_full_in;
    assign w_io_stall     = (r_addr[17:16] == 2'b11) && io_buffer_full_in;
    assign w_accept       = rdy_in && (r_state == S_IDLE) && (w_state_nxt != S_IDLE);

    // Read byte merge. Capture runs even while paused: the RAM keeps
    // answering the held address, so the byte due this cycle would otherwise
    // be overwritten on mem_din_in by the next one before the pause ends.
    always_comb begin
        w_rbuf_cap = r_rbuf;
        if (r_din_vld) begin
            w_rbuf_cap[{r_din_idx, 3'b000} +: 8] = mem_din_in;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (!refresh_rob_cdb_in) begin
                        if (rdy_data_lsc_in) begin
                            w_state_nxt = wr_lsc_in ? S_WRITE : S_READ;
                        end else if (rdy_if_in) begin
                            w_state_nxt = S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (refresh_rob_cdb_in) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_rd_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_WRITE: begin
                    if (w_wr_all) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: outputs and datapath next values (registered below)
    always_comb begin
        w_port_nxt     = r_port;
        w_addr_nxt     = r_addr;
        w_len_nxt      = r_len;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_squash_nxt   = r_squash;
        w_a_vld_nxt    = r_a_vld;
        w_a_idx_nxt    = r_a_idx;
        w_mem_wr_nxt   = 1'b0;
        w_mem_a_nxt    = r_mem_a;
        w_mem_dout_nxt = r_mem_dout;
        w_rdy_data_nxt = 1'b0;
        w_rdy_inst_nxt = 1'b0;
        w_data_l_nxt   = r_data_l;
        w_inst_nxt     = r_inst;

        case (r_state)
            S_IDLE: begin
                // The first byte goes out on the accept edge itself so that
                // byte 0 is on the RAM bus in the first cycle after accept.
                if (w_state_nxt == S_READ) begin
                    w_port_nxt   = !rdy_data_lsc_in;
                    w_addr_nxt   = rdy_data_lsc_in ? addr_lsc_in : addr_if_in;
                    w_len_nxt    = rdy_data_lsc_in ? len_lsc_in : FETCH_LEN;
                    w_squash_nxt = 1'b0;
                    w_cnt_nxt    = 3'd1;
                    w_a_vld_nxt  = 1'b1;
                    w_a_idx_nxt  = 2'd0;
                    w_mem_a_nxt  = rdy_data_lsc_in ? addr_lsc_in : addr_if_in;
                end else if (w_state_nxt == S_WRITE) begin
                    w_port_nxt   = 1'b0;
                    w_addr_nxt   = addr_lsc_in;
                    w_len_nxt    = len_lsc_in;
                    w_wdata_nxt  = data_s_lsc_in;
                    w_squash_nxt = 1'b0;
                    w_mem_a_nxt  = addr_lsc_in;
                    if (w_io_stall_acc) begin
                        w_cnt_nxt = 3'd0;
                    end else begin
                        w_mem_wr_nxt   = 1'b1;
                        w_mem_dout_nxt = data_s_lsc_in[7:0];
                        w_cnt_nxt      = 3'd1;
                    end
                end
            end
            S_READ: begin
                if (w_state_nxt == S_READ) begin
                    // After the last address, mem_a_out is held so the last
                    // byte stays on mem_din_in until it is taken.
                    if (r_cnt < r_len) begin
                        w_mem_a_nxt = r_addr + ADDR_WIDTH'(r_cnt);
                        w_a_idx_nxt = r_cnt[1:0];
                        w_cnt_nxt   = r_cnt + 3'd1;
                    end
                end else begin
                    w_a_vld_nxt = 1'b0;
                    if (w_state_nxt == S_DONE) begin
                        if (r_port) begin
                            w_inst_nxt     = w_rbuf_cap;
                            w_rdy_inst_nxt = 1'b1;
                        end else begin
                            w_data_l_nxt   = w_rbuf_cap;
                            w_rdy_data_nxt = 1'b1;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (refresh_rob_cdb_in) begin
                    w_squash_nxt = 1'b1;
                end
                if (!w_wr_all) begin
                    w_mem_a_nxt = r_addr + ADDR_WIDTH'(r_cnt);
                    if (!w_io_stall) begin
                        w_mem_wr_nxt   = 1'b1;
                        w_mem_dout_nxt = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                        w_cnt_nxt      = r_cnt + 3'd1;
                    end
                end else begin
                    // Committed store: it completes, but a flushed requester
                    // is no longer waiting for its done pulse.
                    w_rdy_data_nxt = !(r_squash || refresh_rob_cdb_in);
                end
            end
            default: begin
                // DONE: pulses fall back to 0 on the way to IDLE.
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_port     <= 1'b0;
            r_addr     <= '0;
            r_len      <= 3'd0;
            r_wdata    <= '0;
            r_cnt      <= 3'd0;
            r_squash   <= 1'b0;
            r_a_vld    <= 1'b0;
            r_a_idx    <= 2'd0;
            r_din_vld  <= 1'b0;
            r_din_idx  <= 2'd0;
            r_rbuf     <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_a    <= '0;
            r_mem_dout <= 8'h00;
            r_rdy_data <= 1'b0;
            r_rdy_inst <= 1'b0;
            r_data_l   <= '0;
            r_inst     <= '0;
        end else begin
            r_din_vld <= r_a_vld;
            r_din_idx <= r_a_idx;
            r_rbuf    <= w_accept ? '0 : w_rbuf_cap;
            if (rdy_in) begin
                r_port     <= w_port_nxt;
                r_addr     <= w_addr_nxt;
                r_len      <= w_len_nxt;
                r_wdata    <= w_wdata_nxt;
                r_cnt      <= w_cnt_nxt;
                r_squash   <= w_squash_nxt;
                r_a_vld    <= w_a_vld_nxt;
                r_a_idx    <= w_a_idx_nxt;
                r_mem_wr   <= w_mem_wr_nxt;
                r_mem_a    <= w_mem_a_nxt;
                r_mem_dout <= w_mem_dout_nxt;
                r_rdy_data <= w_rdy_data_nxt;
                r_rdy_inst <= w_rdy_inst_nxt;
                r_data_l   <= w_data_l_nxt;
                r_inst     <= w_inst_nxt;
            end else begin
                r_mem_wr <= 1'b0;
            end
        end
    end

    assign mem_wr_out       = r_mem_wr;
    assign mem_a_out        = r_mem_a;
    assign mem_dout_out     = r_mem_dout;
    assign rdy_data_lsc_out = r_rdy_data;
    assign rdy_inst_if_out  = r_rdy_inst;
    assign data_l_lsc_out   = r_data_l;
    assign inst_if_out      = r_inst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rdy_data_lsc_in;
    logic        wr_lsc_in;
    logic [31:0] addr_lsc_in;
    logic [2:0]  len_lsc_in;
    logic [31:0] data_s_lsc_in;
    logic [31:0] data_l_lsc_out;
    logic        rdy_data_lsc_out;
    logic        rdy_if_in;
    logic [31:0] addr_if_in;
    logic [31:0] inst_if_out;
    logic        rdy_inst_if_out;
    logic [7:0]  mem_din_in;
    logic [7:0]  mem_dout_out;
    logic [31:0] mem_a_out;
    logic        mem_wr_out;
    logic        io_buffer_full_in;
    logic        refresh_rob_cdb_in;

    logic        pl_en;
    logic [11:0] pl_addr;
    logic [7:0]  pl_dat;
    logic [7:0]  ram [0:4095];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .rdy_in            (rdy),
        .rdy_data_lsc_in   (rdy_data_lsc_in),
        .wr_lsc_in         (wr_lsc_in),
        .addr_lsc_in       (addr_lsc_in),
        .len_lsc_in        (len_lsc_in),
        .data_s_lsc_in     (data_s_lsc_in),
        .data_l_lsc_out    (data_l_lsc_out),
        .rdy_data_lsc_out  (rdy_data_lsc_out),
        .rdy_if_in         (rdy_if_in),
        .addr_if_in        (addr_if_in),
        .inst_if_out       (inst_if_out),
        .rdy_inst_if_out   (rdy_inst_if_out),
        .mem_din_in        (mem_din_in),
        .mem_dout_out      (mem_dout_out),
        .mem_a_out         (mem_a_out),
        .mem_wr_out        (mem_wr_out),
        .io_buffer_full_in (io_buffer_full_in),
        .refresh_rob_cdb_in(refresh_rob_cdb_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read byte appears the cycle after its address.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_dat;
        end else if (mem_wr_out) begin
            ram[mem_a_out[11:0]] <= mem_dout_out;
        end
        mem_din_in <= ram[mem_a_out[11:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Data-port read issued in the current cycle; the next edge is the accept edge.
    task automatic data_rd(input string tag, input logic [31:0] a, input logic [2:0] l,
                           input int done_c, input logic [31:0] exp);
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b0; addr_lsc_in = a; len_lsc_in = l;
        for (int c = 1; c <= done_c + 1; c++) begin
            tick();
            check({tag, "_pulse"}, 32'(rdy_data_lsc_out), 32'(c == done_c));
            if (c == done_c) begin
                check({tag, "_data"}, data_l_lsc_out, exp);
                rdy_data_lsc_in = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        rdy_data_lsc_in = 1'b0; wr_lsc_in = 1'b0; addr_lsc_in = '0; len_lsc_in = 3'd0;
        data_s_lsc_in = '0; rdy_if_in = 1'b0; addr_if_in = '0;
        io_buffer_full_in = 1'b0; refresh_rob_cdb_in = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
        tick(); tick();

        check("rst_mem_wr", 32'(mem_wr_out), 32'd0);
        check("rst_mem_a", mem_a_out, 32'd0);
        check("rst_mem_dout", 32'(mem_dout_out), 32'd0);
        check("rst_rdy_data", 32'(rdy_data_lsc_out), 32'd0);
        check("rst_rdy_inst", 32'(rdy_inst_if_out), 32'd0);
        check("rst_data_l", data_l_lsc_out, 32'd0);
        check("rst_inst", inst_if_out, 32'd0);

        rst = 1'b0;
        tick();
        preload(12'h100, 8'h78); preload(12'h101, 8'h56);
        preload(12'h102, 8'h34); preload(12'h103, 8'h12);
        preload(12'h200, 8'hF0);
        preload(12'h400, 8'hEF); preload(12'h401, 8'hBE);
        preload(12'h402, 8'hAD); preload(12'h403, 8'hDE);
        tick();

        // LW little-endian: addresses in cycles 1..4, done in cycle 6
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b0; addr_lsc_in = 32'h100; len_lsc_in = 3'd4;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 4) check("lw_addr", mem_a_out, 32'h100 + 32'(c - 1));
            check("lw_wr", 32'(mem_wr_out), 32'd0);
            check("lw_pulse", 32'(rdy_data_lsc_out), 32'(c == 6));
            if (c == 6) begin
                check("lw_data", data_l_lsc_out, 32'h12345678);
                check("lw_inst_pulse", 32'(rdy_inst_if_out), 32'd0);
                rdy_data_lsc_in = 1'b0;
            end
        end

        // LB zero-extension: done in cycle 3
        data_rd("lb", 32'h200, 3'd1, 3, 32'h000000F0);

        // SH 0xBEEF to 0x300; upper store bytes must not be written
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b1; addr_lsc_in = 32'h300; len_lsc_in = 3'd2;
        data_s_lsc_in = 32'h1234BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("sh_wr", 32'(mem_wr_out), 32'(c <= 2));
            if (c == 1) begin
                check("sh_a0", mem_a_out, 32'h300);
                check("sh_d0", 32'(mem_dout_out), 32'hEF);
            end
            if (c == 2) begin
                check("sh_a1", mem_a_out, 32'h301);
                check("sh_d1", 32'(mem_dout_out), 32'hBE);
            end
            check("sh_pulse", 32'(rdy_data_lsc_out), 32'(c == 3));
            if (c == 3) rdy_data_lsc_in = 1'b0;
        end
        wr_lsc_in = 1'b0;
        data_rd("sh_rb", 32'h300, 3'd4, 6, 32'h0000BEEF);

        // Arbitration: LH and fetch together; data first, fetch accepted after the data DONE
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b0; addr_lsc_in = 32'h100; len_lsc_in = 3'd2;
        rdy_if_in = 1'b1; addr_if_in = 32'h400;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) check("arb_first_addr", mem_a_out, 32'h100);
            if (c == 6) check("arb_fetch_addr", mem_a_out, 32'h400);
            check("arb_data_pulse", 32'(rdy_data_lsc_out), 32'(c == 4));
            check("arb_inst_pulse", 32'(rdy_inst_if_out), 32'(c == 11));
            if (c == 4) begin
                check("arb_data", data_l_lsc_out, 32'h00005678);
                rdy_data_lsc_in = 1'b0;
            end
            if (c == 11) begin
                check("arb_inst", inst_if_out, 32'hDEADBEEF);
                rdy_if_in = 1'b0;
            end
        end

        // Refresh in cycle 3 of an LW: no pulse, IDLE next cycle (an LB is accepted at once)
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b0; addr_lsc_in = 32'h100; len_lsc_in = 3'd4;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("rf_rd_pulse", 32'(rdy_data_lsc_out), 32'd0);
        end
        refresh_rob_cdb_in = 1'b1; rdy_data_lsc_in = 1'b0;
        tick();
        refresh_rob_cdb_in = 1'b0;
        check("rf_rd_pulse4", 32'(rdy_data_lsc_out), 32'd0);
        data_rd("rf_rd_next_lb", 32'h200, 3'd1, 3, 32'h000000F0);

        // Refresh during SW: all four bytes written, no done pulse
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b1; addr_lsc_in = 32'h500; len_lsc_in = 3'd4;
        data_s_lsc_in = 32'hCAFEF00D;
        for (int c = 1; c <= 6; c++) begin
            tick();
            refresh_rob_cdb_in = (c == 2);
            if (c == 2) rdy_data_lsc_in = 1'b0;
            check("rf_sw_wr", 32'(mem_wr_out), 32'(c <= 4));
            if (c <= 4) check("rf_sw_addr", mem_a_out, 32'h500 + 32'(c - 1));
            check("rf_sw_pulse", 32'(rdy_data_lsc_out), 32'd0);
        end
        wr_lsc_in = 1'b0;
        data_rd("rf_sw_rb", 32'h500, 3'd4, 6, 32'hCAFEF00D);

        // Refresh while IDLE: request not accepted that edge, so done slips by one
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b0; addr_lsc_in = 32'h200; len_lsc_in = 3'd1;
        refresh_rob_cdb_in = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            refresh_rob_cdb_in = 1'b0;
            check("rf_idle_pulse", 32'(rdy_data_lsc_out), 32'(c == 4));
            if (c == 4) begin
                check("rf_idle_data", data_l_lsc_out, 32'h000000F0);
                rdy_data_lsc_in = 1'b0;
            end
        end

        // Pause for 3 cycles mid-LW: same result, pulse delayed 6 -> 9
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b0; addr_lsc_in = 32'h100; len_lsc_in = 3'd4;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 3) rdy = 1'b0;
            if (c == 6) rdy = 1'b1;
            check("pause_wr", 32'(mem_wr_out), 32'd0);
            check("pause_pulse", 32'(rdy_data_lsc_out), 32'(c == 9));
            if (c == 9) begin
                check("pause_data", data_l_lsc_out, 32'h12345678);
                rdy_data_lsc_in = 1'b0;
            end
        end

        // SB to the I/O window with the buffer full for 2 cycles
        rdy_data_lsc_in = 1'b1; wr_lsc_in = 1'b1; addr_lsc_in = 32'h00030000; len_lsc_in = 3'd1;
        data_s_lsc_in = 32'h000000A5; io_buffer_full_in = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) io_buffer_full_in = 1'b0;
            check("io_wr", 32'(mem_wr_out), 32'(c == 3));
            if (c == 3) begin
                check("io_addr", mem_a_out, 32'h00030000);
                check("io_dout", 32'(mem_dout_out), 32'hA5);
            end
            check("io_pulse", 32'(rdy_data_lsc_out), 32'(c == 4));
            if (c == 4) rdy_data_lsc_in = 1'b0;
        end
        wr_lsc_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
